// File: rtl/alu_exec_unit.sv
// Execute-stage ALU. Add/xor/sub/slt finish in one cycle. sll/srl shift one bit per
// cycle under a ready/start/valid handshake, so no barrel shifter is needed.
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               flush,
    input  logic [2:0]         alu_control,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               ready,
    output logic               valid,
    output logic [WIDTH-1:0]   result,
    output logic               zero
);
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_XOR = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_SLT = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               left_q, left_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               valid_q, valid_d;

    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH-1:0]   shift_nxt;
    logic               is_shift;

    always_comb begin
        alu_res = '0;
        case (alu_control)
            OP_ADD:         alu_res = a + b;
            OP_XOR:         alu_res = a ^ b;
            OP_SUB:         alu_res = a - b;
            OP_SLT:         alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL, OP_SRL: alu_res = b;  // only reached with shamt == 0
            default:        alu_res = '0;
        endcase
    end

    assign is_shift  = (alu_control == OP_SLL) || (alu_control == OP_SRL);
    assign shift_nxt = left_q ? (shreg_q << 1) : (shreg_q >> 1);

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        left_d   = left_q;
        result_d = result_q;
        zero_d   = zero_q;
        valid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // flush beats a same-cycle start
                if (start && !flush) begin
                    if (is_shift && (shamt != '0)) begin
                        shreg_d = b;
                        cnt_d   = shamt;
                        left_d  = (alu_control == OP_SLL);
                        state_d = SHIFT;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        valid_d  = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    shreg_d = shift_nxt;
                    cnt_d   = cnt_q - SHAMT_W'(1);
                    if (cnt_q == SHAMT_W'(1)) begin
                        result_d = shift_nxt;
                        zero_d   = (shift_nxt == '0);
                        valid_d  = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            left_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            left_q   <= left_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
        end
    end

    assign ready  = (state_q == IDLE);
    assign valid  = valid_q;
    assign result = result_q;
    assign zero   = zero_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: single-cycle ops, iterative shifts, flush and reset.
module tb_alu_exec_unit;
    logic        clk, reset, start, flush;
    logic [2:0]  alu_control;
    logic [31:0] a, b, result;
    logic [4:0]  shamt;
    logic        ready, valid, zero;

    int n_cmp = 0;
    int n_bad = 0;

    alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush),
        .alu_control(alu_control), .a(a), .b(b), .shamt(shamt),
        .ready(ready), .valid(valid), .result(result), .zero(zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drive one start for a single cycle; returns 1 ns after the accepting edge
    task automatic issue(input logic [2:0] c, input logic [31:0] aa, input logic [31:0] bb,
                         input logic [4:0] sh);
        alu_control = c; a = aa; b = bb; shamt = sh; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        issue(3'b001, 32'h3, 32'h0, 5'd0);
        n_cmp++; if (result !== 32'h3) begin n_bad++; $display("FAIL pre_reset_xor result=%h exp=%h", result, 32'h3); end
        #3 reset = 1'b1;
        #1;
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL async_reset ready=%b exp=1", ready); end
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL async_reset valid=%b exp=0", valid); end
        n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL async_reset result=%h exp=0", result); end
        n_cmp++; if (zero !== 1'b1) begin n_bad++; $display("FAIL async_reset zero=%b exp=1", zero); end
        tick();
        reset = 1'b0;
        issue(3'b000, 32'd5, 32'd7, 5'd0);
        n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL add_valid valid=%b exp=1", valid); end
        n_cmp++; if (result !== 32'd12) begin n_bad++; $display("FAIL add_result result=%h exp=%h", result, 32'd12); end
        n_cmp++; if (zero !== 1'b0) begin n_bad++; $display("FAIL add_zero zero=%b exp=0", zero); end
        tick();
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL valid_pulse valid=%b exp=0", valid); end
        n_cmp++; if (result !== 32'd12) begin n_bad++; $display("FAIL result_hold result=%h exp=%h", result, 32'd12); end
    endtask

    task automatic test_arith();
        logic [2:0]  ops [6] = '{3'b010, 3'b011, 3'b011, 3'b000, 3'b001, 3'b110};
        logic [31:0] av  [6] = '{32'd9, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'hA5A5A5A5, 32'h1234};
        logic [31:0] bv  [6] = '{32'd9, 32'd1, 32'hFFFFFFFF, 32'd1, 32'h0F0F0F0F, 32'h5678};
        logic [31:0] ev  [6] = '{32'd0, 32'd1, 32'd0, 32'd0, 32'hAAAAAAAA, 32'd0};
        logic        ez  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], av[i], bv[i], 5'd0);
            n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL arith%0d_valid valid=%b exp=1", i, valid); end
            n_cmp++; if (result !== ev[i]) begin n_bad++; $display("FAIL arith%0d_result result=%h exp=%h", i, result, ev[i]); end
            n_cmp++; if (zero !== ez[i]) begin n_bad++; $display("FAIL arith%0d_zero zero=%b exp=%b", i, zero, ez[i]); end
            tick();
        end
    endtask

    task automatic test_shift();
        issue(3'b100, 32'h0, 32'h00000001, 5'd31);
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL sll_busy ready=%b exp=0", ready); end
        for (int i = 1; i <= 30; i++) begin
            if (i >= 5 && i <= 7) begin
                alu_control = 3'b000; a = 32'd1; b = 32'd1; shamt = 5'd0; start = 1'b1;
            end else start = 1'b0;
            tick();
            n_cmp++; if (ready !== 1'b0 || valid !== 1'b0) begin n_bad++; $display("FAIL sll_wait%0d ready=%b valid=%b exp=0/0", i, ready, valid); end
        end
        start = 1'b0;
        tick();
        n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL sll31_valid valid=%b exp=1", valid); end
        n_cmp++; if (result !== 32'h80000000) begin n_bad++; $display("FAIL sll31_result result=%h exp=80000000", result); end
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL sll31_ready ready=%b exp=1", ready); end

        issue(3'b101, 32'h0, 32'h80000000, 5'd4);
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL srl_wait%0d valid=%b exp=0", i, valid); end
        end
        tick();
        n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL srl4_valid valid=%b exp=1", valid); end
        n_cmp++; if (result !== 32'h08000000) begin n_bad++; $display("FAIL srl4_result result=%h exp=08000000", result); end

        issue(3'b100, 32'h0, 32'h00001234, 5'd0);
        n_cmp++; if (valid !== 1'b1 || ready !== 1'b1) begin n_bad++; $display("FAIL sll0_valid valid=%b ready=%b exp=1/1", valid, ready); end
        n_cmp++; if (result !== 32'h00001234) begin n_bad++; $display("FAIL sll0_result result=%h exp=00001234", result); end
        tick();
    endtask

    task automatic test_back_to_back();
        alu_control = 3'b001; a = 32'h0000F0F0; b = 32'h00000FF0; start = 1'b1; shamt = 5'd0;
        tick();
        n_cmp++; if (valid !== 1'b1 || result !== 32'h0000FF00) begin n_bad++; $display("FAIL b2b_xor valid=%b result=%h exp=1/0000ff00", valid, result); end
        alu_control = 3'b000; a = 32'd100; b = 32'd23;
        tick();
        n_cmp++; if (valid !== 1'b1 || result !== 32'd123) begin n_bad++; $display("FAIL b2b_add valid=%b result=%h exp=1/%h", valid, result, 32'd123); end
        alu_control = 3'b010; a = 32'd5; b = 32'd7;
        tick();
        n_cmp++; if (valid !== 1'b1 || result !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL b2b_sub valid=%b result=%h exp=1/fffffffe", valid, result); end
        start = 1'b0;
        // shift completion followed by a start in the valid cycle
        issue(3'b100, 32'h0, 32'h3, 5'd1);
        alu_control = 3'b000; a = 32'd1; b = 32'd1; shamt = 5'd0; start = 1'b1;
        tick();
        n_cmp++; if (valid !== 1'b1 || result !== 32'h6 || ready !== 1'b1) begin n_bad++; $display("FAIL sll1_done valid=%b result=%h ready=%b exp=1/6/1", valid, result, ready); end
        tick();
        start = 1'b0;
        n_cmp++; if (valid !== 1'b1 || result !== 32'h2) begin n_bad++; $display("FAIL zero_bubble valid=%b result=%h exp=1/2", valid, result); end
        tick();
    endtask

    task automatic test_flush();
        issue(3'b000, 32'd40, 32'd2, 5'd0);
        issue(3'b101, 32'h0, 32'h0000FFFF, 5'd10);
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++; if (valid !== 1'b0 || ready !== 1'b1) begin n_bad++; $display("FAIL flush_abort valid=%b ready=%b exp=0/1", valid, ready); end
        n_cmp++; if (result !== 32'd42) begin n_bad++; $display("FAIL flush_hold result=%h exp=%h", result, 32'd42); end
        for (int i = 0; i < 12; i++) begin
            tick();
            if (valid !== 1'b0) begin n_cmp++; n_bad++; $display("FAIL flush_late_valid valid=%b exp=0", valid); end
        end
        alu_control = 3'b000; a = 32'd1; b = 32'd2; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        n_cmp++; if (valid !== 1'b0 || result !== 32'd42 || ready !== 1'b1) begin n_bad++; $display("FAIL start_flush valid=%b result=%h ready=%b exp=0/%h/1", valid, result, ready, 32'd42); end
        tick();
    endtask

    task automatic test_reset_mid_shift();
        int cyc;
        issue(3'b100, 32'h0, 32'h5, 5'd20);
        for (int i = 0; i < 5; i++) tick();
        #3 reset = 1'b1;
        #1;
        n_cmp++; if (ready !== 1'b1 || valid !== 1'b0) begin n_bad++; $display("FAIL rst_shift_hs ready=%b valid=%b exp=1/0", ready, valid); end
        n_cmp++; if (result !== 32'h0 || zero !== 1'b1) begin n_bad++; $display("FAIL rst_shift_out result=%h zero=%b exp=0/1", result, zero); end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid !== 1'b0) begin n_cmp++; n_bad++; $display("FAIL rst_shift_ghost valid=%b exp=0", valid); end
        end
        issue(3'b101, 32'h0, 32'h00000100, 5'd3);
        cyc = 0;
        while (valid !== 1'b1 && cyc < 40) begin tick(); cyc++; end
        n_cmp++; if (cyc !== 3) begin n_bad++; $display("FAIL post_rst_latency cycles=%0d exp=3", cyc); end
        n_cmp++; if (result !== 32'h20) begin n_bad++; $display("FAIL post_rst_result result=%h exp=00000020", result); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0;
        alu_control = 3'b000; a = '0; b = '0; shamt = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        test_reset();
        test_arith();
        test_shift();
        test_back_to_back();
        test_flush();
        test_reset_mid_shift();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
